// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous level into clk, debounces it with a consecutive-sample
// counter, and produces a clean level, single-cycle rise/fall strobes and a rise counter.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] rise_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        RISING      = 2'b01,
        STABLE_HIGH = 2'b10,
        FALLING     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [7:0]             rise_cnt_q, rise_cnt_d;
    logic                   s;

    // Plain shift chain; only stage 0 may go metastable, everything else reads s.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], d_in};
    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        rise_cnt_d = rise_cnt_q;
        case (state_q)
            STABLE_LOW, RISING: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == STABLE_LIM) begin
                    state_d    = STABLE_HIGH;
                    cnt_d      = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                    rise_cnt_d = rise_cnt_q + 8'd1;
                end else begin
                    state_d = RISING;
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == STABLE_LIM) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    state_d = FALLING;
                    cnt_d   = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= STABLE_LOW;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rise_cnt_q <= 8'd0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign level    = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign rise_cnt = rise_cnt_q;

endmodule
